fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 17 +
 rtl/pc_register.sv | 29 ++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter: load has priority over increment, otherwise holds.
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [31:0] i_load_value,
  input  logic        i_incr,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_value;
    end else if (i_incr) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, ROM addressing, IF/ID register and
// misaligned-redirect trap.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned TAM_POSICIONES = 1024,
  parameter int unsigned TAM_PALABRA    = 32,
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  localparam int unsigned ADDR_W        = $clog2(TAM_POSICIONES)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   STALL,
  input  logic                   BRANCH_TAKEN,
  input  logic [31:0]            BRANCH_TARGET,
  input  logic [TAM_PALABRA-1:0] INSTRUCTION_IN,
  output logic [ADDR_W-1:0]      INS_ADDRESS,
  output logic                   READ_EN,
  output logic                   CE,
  output logic [31:0]            PC_OUT,
  output logic [TAM_PALABRA-1:0] INSTRUCTION_OUT,
  output logic                   VALID_OUT,
  output logic                   ERROR
);

  localparam logic [TAM_PALABRA-1:0] NOP_WORD = TAM_PALABRA'(NOP_INSTR);

  fetch_state_t r_state;
  fetch_state_t w_state_next;

  logic [31:0]            w_pc;
  logic                   w_pc_load;
  logic [31:0]            w_pc_load_value;
  logic                   w_pc_incr;
  logic                   w_capture;
  logic                   w_flush;
  logic                   w_halt;
  logic                   w_fetch_en;

  logic [31:0]            r_pc_out;
  logic [TAM_PALABRA-1:0] r_instr;
  logic                   r_valid;
  logic                   r_error;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .i_clk        (CLK),
    .i_reset      (RESET),
    .i_load       (w_pc_load),
    .i_load_value (w_pc_load_value),
    .i_incr       (w_pc_incr),
    .o_pc         (w_pc)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A redirect outranks STALL: the wrong-path instruction is squashed either way.
  always_comb begin
    w_state_next    = r_state;
    w_pc_load       = 1'b0;
    w_pc_load_value = RESET_PC;
    w_pc_incr       = 1'b0;
    w_capture       = 1'b0;
    w_flush         = 1'b0;
    w_halt          = 1'b0;
    w_fetch_en      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_state_next = FETCH;
        w_pc_load    = 1'b1;
      end
      FETCH: begin
        w_fetch_en = 1'b1;
        if (BRANCH_TAKEN) begin
          if (is_word_aligned(BRANCH_TARGET)) begin
            w_pc_load       = 1'b1;
            w_pc_load_value = BRANCH_TARGET;
            w_flush         = 1'b1;
          end else begin
            w_state_next = HALT;
            w_halt       = 1'b1;
          end
        end else if (!STALL) begin
          w_capture = 1'b1;
          w_pc_incr = 1'b1;
        end
      end
      HALT: begin
        w_state_next = HALT;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pc_out <= 32'h0000_0000;
      r_instr  <= NOP_WORD;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_pc_out <= w_pc;
        r_instr  <= INSTRUCTION_IN;
        r_valid  <= 1'b1;
      end else if (w_flush || w_halt) begin
        r_instr <= NOP_WORD;
        r_valid <= 1'b0;
      end
      if (w_halt) begin
        r_error <= 1'b1;
      end
    end
  end

  assign INS_ADDRESS     = w_pc[ADDR_W+1:2];
  assign CE              = w_fetch_en;
  assign READ_EN         = w_fetch_en;
  assign PC_OUT          = r_pc_out;
  assign INSTRUCTION_OUT = r_instr;
  assign VALID_OUT       = r_valid;
  assign ERROR           = r_error;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a 1024-word and a 16-word instance share stimulus and
// are each checked every cycle against a behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] INS_A = 32'h1111_1111;
  localparam logic [31:0] INS_B = 32'h2222_2222;
  localparam logic [31:0] INS_C = 32'h3333_3333;
  localparam int M_IDLE = 0;
  localparam int M_FETCH = 1;
  localparam int M_HALT = 2;

  logic        CLK;
  logic        RESET;
  logic        STALL;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;

  logic [31:0] rom0 [1024];
  logic [31:0] rom1 [16];

  logic [9:0]  addr0;
  logic [3:0]  addr1;
  logic [31:0] instr_in0, instr_in1, pc_out0, pc_out1, instr_out0, instr_out1;
  logic        rd0, rd1, ce0, ce1, valid0, valid1, err0, err1;

  assign instr_in0 = rom0[addr0];
  assign instr_in1 = rom1[addr1];

  fetch_unit u_dut0 (
    .CLK             (CLK),
    .RESET           (RESET),
    .STALL           (STALL),
    .BRANCH_TAKEN    (BRANCH_TAKEN),
    .BRANCH_TARGET   (BRANCH_TARGET),
    .INSTRUCTION_IN  (instr_in0),
    .INS_ADDRESS     (addr0),
    .READ_EN         (rd0),
    .CE              (ce0),
    .PC_OUT          (pc_out0),
    .INSTRUCTION_OUT (instr_out0),
    .VALID_OUT       (valid0),
    .ERROR           (err0)
  );

  fetch_unit #(
    .TAM_POSICIONES (16)
  ) u_dut1 (
    .CLK             (CLK),
    .RESET           (RESET),
    .STALL           (STALL),
    .BRANCH_TAKEN    (BRANCH_TAKEN),
    .BRANCH_TARGET   (BRANCH_TARGET),
    .INSTRUCTION_IN  (instr_in1),
    .INS_ADDRESS     (addr1),
    .READ_EN         (rd1),
    .CE              (ce1),
    .PC_OUT          (pc_out1),
    .INSTRUCTION_OUT (instr_out1),
    .VALID_OUT       (valid1),
    .ERROR           (err1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model state per instance: architectural view only.
  int          m_st    [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_pcout [2];
  logic [31:0] m_ins   [2];
  logic        m_valid [2];
  logic        m_err   [2];
  int unsigned m_tam   [2] = '{1024, 16};

  function automatic logic [31:0] m_word(input int k);
    logic [31:0] idx;
    idx = (m_pc[k] >> 2) % m_tam[k];
    return idx;
  endfunction

  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (RESET) begin
        m_st[k] = M_IDLE; m_pc[k] = 32'h0; m_pcout[k] = 32'h0;
        m_ins[k] = NOP; m_valid[k] = 1'b0; m_err[k] = 1'b0;
      end else if (m_st[k] == M_IDLE) begin
        m_st[k] = M_FETCH; m_pc[k] = 32'h0;
      end else if (m_st[k] == M_FETCH) begin
        if (BRANCH_TAKEN && BRANCH_TARGET[1:0] != 2'b00) begin
          m_st[k] = M_HALT; m_err[k] = 1'b1; m_ins[k] = NOP; m_valid[k] = 1'b0;
        end else if (BRANCH_TAKEN) begin
          m_pc[k] = BRANCH_TARGET; m_ins[k] = NOP; m_valid[k] = 1'b0;
        end else if (!STALL) begin
          m_pcout[k] = m_pc[k];
          m_ins[k] = (k == 0) ? rom0[m_word(0)] : rom1[m_word(1)];
          m_valid[k] = 1'b1;
          m_pc[k] = m_pc[k] + 32'd4;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      logic fe0, fe1;
      fe0 = (m_st[0] == M_FETCH);
      fe1 = (m_st[1] == M_FETCH);
      chk("m0 valid", 32'(valid0), 32'(m_valid[0]));
      chk("m0 instr", instr_out0, m_ins[0]);
      chk("m0 ce", 32'(ce0), 32'(fe0));
      chk("m0 read_en", 32'(rd0), 32'(fe0));
      chk("m0 addr", 32'(addr0), m_word(0));
      chk("m0 error", 32'(err0), 32'(m_err[0]));
      if (m_valid[0]) chk("m0 pc_out", pc_out0, m_pcout[0]);
      chk("m1 valid", 32'(valid1), 32'(m_valid[1]));
      chk("m1 instr", instr_out1, m_ins[1]);
      chk("m1 ce", 32'(ce1), 32'(fe1));
      chk("m1 read_en", 32'(rd1), 32'(fe1));
      chk("m1 addr", 32'(addr1), m_word(1));
      chk("m1 error", 32'(err1), 32'(m_err[1]));
      if (m_valid[1]) chk("m1 pc_out", pc_out1, m_pcout[1]);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom0[i] = 32'hC0DE_0000 | i;
    for (int i = 0; i < 16; i++) rom1[i] = 32'h5EED_0000 | i;
    rom0[0] = INS_A; rom0[1] = INS_B; rom0[2] = INS_C;
    RESET = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst valid", 32'(valid0), 32'h0);
    chk("rst instr", instr_out0, NOP);
    chk("rst pc_out", pc_out0, 32'h0);
    chk("rst ce", 32'(ce0), 32'h0);
    chk("rst read_en", 32'(rd0), 32'h0);
    chk("rst error", 32'(err0), 32'h0);

    // Free run: NOP, A, B, then stall on B
    RESET = 1'b0;
    tick();
    chk("run0 valid", 32'(valid0), 32'h0);
    chk("run0 instr", instr_out0, NOP);
    chk("run0 addr", 32'(addr0), 32'd0);
    tick();
    chk("run1 instr", instr_out0, INS_A);
    chk("run1 pc_out", pc_out0, 32'h0);
    tick();
    chk("run2 instr", instr_out0, INS_B);
    chk("run2 pc_out", pc_out0, 32'h4);
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall instr", instr_out0, INS_B);
      chk("stall pc_out", pc_out0, 32'h4);
      chk("stall addr", 32'(addr0), 32'd2);
      chk("stall ce", 32'(ce0), 32'h1);
    end
    STALL = 1'b0;
    tick();
    chk("unstall instr", instr_out0, INS_C);
    chk("unstall pc_out", pc_out0, 32'h8);

    // Branch beats stall
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h40; STALL = 1'b1;
    tick();
    chk("br valid", 32'(valid0), 32'h0);
    chk("br instr", instr_out0, NOP);
    chk("br addr", 32'(addr0), 32'd16);
    BRANCH_TAKEN = 1'b0; STALL = 1'b0;
    tick();
    chk("br tgt instr", instr_out0, 32'hC0DE_0010);
    chk("br tgt pc_out", pc_out0, 32'h40);
    tick(); tick();

    // 32-bit PC wrap
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'hFFFF_FFFC;
    tick();
    BRANCH_TAKEN = 1'b0;
    tick();
    chk("wrap pc_out", pc_out0, 32'hFFFF_FFFC);
    chk("wrap instr", instr_out0, 32'hC0DE_03FF);
    chk("wrap addr", 32'(addr0), 32'd0);
    tick();
    chk("wrap next instr", instr_out0, INS_A);

    // Misaligned target traps; HALT ignores inputs
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h42;
    tick();
    chk("mis error", 32'(err0), 32'h1);
    chk("mis ce", 32'(ce0), 32'h0);
    chk("mis valid", 32'(valid0), 32'h0);
    for (int i = 0; i < 10; i++) begin
      BRANCH_TAKEN = i[0]; STALL = i[1]; BRANCH_TARGET = 32'h80;
      tick();
      chk("halt error", 32'(err0), 32'h1);
      chk("halt ce", 32'(ce0), 32'h0);
      chk("halt valid", 32'(valid0), 32'h0);
      chk("halt instr", instr_out0, NOP);
    end
    BRANCH_TAKEN = 1'b0; STALL = 1'b0; RESET = 1'b1;
    tick();
    chk("halt rst error", 32'(err0), 32'h0);
    chk("halt rst ce", 32'(ce0), 32'h0);
    RESET = 1'b0;
    tick(); tick();
    chk("refetch instr", instr_out0, INS_A);
    chk("refetch pc_out", pc_out0, 32'h0);

    // Reset during stall
    tick();
    STALL = 1'b1;
    tick();
    RESET = 1'b1;
    tick();
    chk("stall rst valid", 32'(valid0), 32'h0);
    chk("stall rst ce", 32'(ce0), 32'h0);
    chk("stall rst instr", instr_out0, NOP);
    RESET = 1'b0; STALL = 1'b0;
    tick(); tick();
    chk("stall rst refetch", instr_out0, INS_A);
    chk("stall rst pc_out", pc_out0, 32'h0);

    // Reset during branch
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h40; RESET = 1'b1;
    tick();
    chk("br rst valid", 32'(valid0), 32'h0);
    chk("br rst ce", 32'(ce0), 32'h0);
    chk("br rst addr", 32'(addr0), 32'd0);
    BRANCH_TAKEN = 1'b0; RESET = 1'b0;

    // 16-word ROM address wrap
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 16) chk("w16 addr 15", 32'(addr1), 32'd15);
      if (t == 17) chk("w16 addr 0", 32'(addr1), 32'd0);
      if (t == 18) begin
        chk("w16 pc_out", pc_out1, 32'h40);
        chk("w16 instr", instr_out1, 32'h5EED_0000);
        chk("w16 valid", 32'(valid1), 32'h1);
      end
    end
    chk("w16 error", 32'(err1), 32'h0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
